// File: rtl/approx_mul_arbiter.sv
// approx_mul_arbiter: round-robin sharing of one external 8x8 multiplier,
// with a registered operand stage and a tagged, backpressured response stage.
module approx_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*8-1:0] req_x,
  input  logic [NREQ*8-1:0] req_y,
  output logic [7:0]        mul_x,
  output logic [7:0]        mul_y,
  input  logic [15:0]       mul_z,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_z,
  output logic              busy
);
  logic [IDW-1:0] ptr_q, ptr_d, op_id_q, op_id_d, rsp_id_q, rsp_id_d, gnt_id, idx;
  logic [7:0]     mul_x_q, mul_x_d, mul_y_q, mul_y_d;
  logic [15:0]    rsp_z_q, rsp_z_d;
  logic           op_vld_q, op_vld_d, rsp_valid_q, rsp_valid_d;
  logic           adv_r, adv_o, gnt_any, acc;
  // Scan downward so the requester closest after ptr is the last (winning) hit.
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(ptr_q) + k) % NREQ);
      if (req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = idx;
      end
    end
  end
  assign adv_r     = !rsp_valid_q || rsp_ready;
  assign adv_o     = !op_vld_q || adv_r;
  assign acc       = adv_o && gnt_any && !rst;
  assign req_ready = acc ? (NREQ'(1) << gnt_id) : '0;
  always_comb begin
    ptr_d       = ptr_q;
    op_vld_d    = op_vld_q;
    op_id_d     = op_id_q;
    mul_x_d     = mul_x_q;
    mul_y_d     = mul_y_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_z_d     = rsp_z_q;
    if (adv_o) op_vld_d = acc;
    if (acc) begin
      ptr_d   = gnt_id;
      op_id_d = gnt_id;
      mul_x_d = req_x[{gnt_id, 3'b000} +: 8];
      mul_y_d = req_y[{gnt_id, 3'b000} +: 8];
    end
    if (adv_r) rsp_valid_d = op_vld_q;
    if (adv_r && op_vld_q) begin
      rsp_z_d  = mul_z;
      rsp_id_d = op_id_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= IDW'(NREQ - 1);
      op_vld_q    <= 1'b0;
      op_id_q     <= '0;
      mul_x_q     <= '0;
      mul_y_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_z_q     <= '0;
    end else begin
      ptr_q       <= ptr_d;
      op_vld_q    <= op_vld_d;
      op_id_q     <= op_id_d;
      mul_x_q     <= mul_x_d;
      mul_y_q     <= mul_y_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
    end
  end
  assign mul_x     = mul_x_q;
  assign mul_y     = mul_y_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign busy      = op_vld_q || rsp_valid_q;
endmodule

// File: tb/tb_approx_mul_arbiter.sv
// tb_approx_mul_arbiter: directed and random stimulus against a queue-based
// model of the arbiter, with an exact stub multiplier.
module tb_approx_mul_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] req_valid, req_ready;
  logic [N*8-1:0] req_x, req_y;
  logic [7:0] mul_x, mul_y;
  logic [15:0] mul_z, rsp_z;
  logic rsp_valid, rsp_ready, busy;
  logic [1:0] rsp_id;

  always #5 clk = ~clk;
  assign mul_z = 16'(mul_x) * 16'(mul_y);

  approx_mul_arbiter #(.NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .busy(busy)
  );

  // In-flight transactions, oldest first; in_r marks the one shown on rsp_*.
  typedef struct {int id; int x; int y; bit in_r;} txn_t;
  txn_t q[$];
  int ptr_m, lx, ly;
  int tests, fails;
  bit v[N], keep[N];
  int xs[N], ys[N];
  logic [N-1:0] acc_dut, m_ready;
  bit m_any, m_rv, dut_hs;
  int m_g;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]     = v[i];
      req_x[8*i +: 8]  = 8'(xs[i]);
      req_y[8*i +: 8]  = 8'(ys[i]);
    end
  endtask

  function automatic void predict();
    bit can;
    m_rv  = q.size() > 0 && q[0].in_r;
    m_any = 1'b0;
    m_g   = 0;
    for (int k = 1; k <= N && !m_any; k++)
      if (req_valid[(ptr_m + k) % N]) begin
        m_any = 1'b1;
        m_g   = (ptr_m + k) % N;
      end
    can     = !rst && (q.size() < 2 || (m_rv && rsp_ready));
    m_ready = (can && m_any) ? (N'(1) << m_g) : '0;
  endfunction

  task automatic settle();
    drive();
    #1;
    predict();
    acc_dut = req_valid & req_ready;
    dut_hs  = rsp_valid && rsp_ready;
    chk("req_ready", 32'(req_ready), 32'(m_ready));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("busy", 32'(busy), (q.size() > 0) ? 1 : 0);
    chk("mul_x", 32'(mul_x), lx);
    chk("mul_y", 32'(mul_y), ly);
    if (m_rv) begin
      chk("rsp_id", 32'(rsp_id), q[0].id);
      chk("rsp_z", 32'(rsp_z), q[0].x * q[0].y);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      q.delete();
      ptr_m = N - 1;
      lx = 0;
      ly = 0;
    end else begin
      if (m_rv && rsp_ready) void'(q.pop_front());
      if (q.size() > 0 && !q[0].in_r) q[0].in_r = 1'b1;
      if (m_ready != '0) begin
        q.push_back('{m_g, xs[m_g], ys[m_g], 1'b0});
        ptr_m = m_g;
        lx = xs[m_g];
        ly = ys[m_g];
      end
    end
    for (int i = 0; i < N; i++)
      if (acc_dut[i]) begin
        if (keep[i]) begin
          xs[i] = $urandom_range(0, 255);
          ys[i] = $urandom_range(0, 255);
        end else v[i] = 1'b0;
      end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0;
      keep[i] = 1'b0;
    end
    rsp_ready = 1'b1;
    repeat (n) begin settle(); tick(); end
  endtask

  initial begin
    int cnt0, cnt2, nacc, nhs;
    tests = 0; fails = 0;
    rst = 1'b1; rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin v[i] = 0; keep[i] = 0; xs[i] = 0; ys[i] = 0; end
    ptr_m = N - 1; lx = 0; ly = 0;
    drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    settle(); tick();
    rst = 1'b0;
    settle();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_mul_x", 32'(mul_x), 0);
    chk("reset_rsp_valid", 32'(rsp_valid), 0);
    tick();

    v[2] = 1; xs[2] = 200; ys[2] = 3;
    settle(); chk("single_grant", 32'(req_ready), 32'h4); tick();
    settle(); chk("single_mul_x", 32'(mul_x), 200); chk("single_mul_y", 32'(mul_y), 3); tick();
    settle(); chk("single_rsp_valid", 32'(rsp_valid), 1);
    chk("single_rsp_id", 32'(rsp_id), 2); chk("single_rsp_z", 32'(rsp_z), 600); tick();

    v[1] = 1; xs[1] = 255; ys[1] = 255;
    settle(); tick();
    v[3] = 1; xs[3] = 0; ys[3] = 255;
    settle(); tick();
    settle(); chk("bound_max_z", 32'(rsp_z), 65025); chk("bound_max_id", 32'(rsp_id), 1); tick();
    settle(); chk("bound_zero_valid", 32'(rsp_valid), 1); chk("bound_zero_z", 32'(rsp_z), 0); tick();
    idle(3);

    for (int i = 0; i < N; i++) begin
      v[i] = 1; keep[i] = 1; xs[i] = $urandom_range(0, 255); ys[i] = $urandom_range(0, 255);
    end
    for (int k = 0; k < 8; k++) begin
      settle(); chk("rr_grant", 32'(req_ready), 32'(1) << (k % 4));
      if (k >= 2) chk("rr_rsp_valid", 32'(rsp_valid), 1);
      tick();
    end
    idle(3);

    v[0] = 1; keep[0] = 1; v[2] = 1; keep[2] = 1;
    cnt0 = 0; cnt2 = 0;
    for (int k = 0; k < 8; k++) begin
      settle(); chk("fair_grant", 32'(req_ready), (k % 2 == 1) ? 32'h4 : 32'h1);
      cnt0 += int'(acc_dut[0]); cnt2 += int'(acc_dut[2]);
      tick();
    end
    chk("fair_count0", cnt0, 4);
    chk("fair_count2", cnt2, 4);
    idle(3);

    for (int i = 0; i < N; i++) begin
      v[i] = 1; xs[i] = $urandom_range(0, 255); ys[i] = $urandom_range(0, 255);
    end
    rsp_ready = 1'b0; nacc = 0;
    repeat (5) begin settle(); nacc += $countones(acc_dut); tick(); end
    chk("bp_accepts", nacc, 2);
    rsp_ready = 1'b1; nhs = 0;
    repeat (8) begin settle(); nhs += int'(dut_hs); tick(); end
    chk("bp_drained", nhs, 4);
    idle(2);

    for (int i = 0; i < N; i++) begin v[i] = 1; keep[i] = 1; end
    rsp_ready = 1'b0;
    repeat (3) begin settle(); tick(); end
    settle(); chk("mid_full_busy", 32'(busy), 1);
    rst = 1'b1; tick();
    settle(); tick();
    rst = 1'b0;
    settle();
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_mul_x", 32'(mul_x), 0);
    chk("mid_rst_grant", 32'(req_ready), 32'h1);
    tick();
    idle(3);

    repeat (3000) begin
      for (int i = 0; i < N; i++)
        if (!v[i] && $urandom_range(0, 2) == 0) begin
          v[i] = 1;
          xs[i] = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
          ys[i] = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 255);
        end
      rsp_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 199) == 0;
      settle(); tick();
    end
    rst = 1'b0;
    idle(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
